wb_master_arbiter: RTL and testbench

- Shares the single 16-bit-data, 24-bit-address Wishbone bus between N masters: instruction-cache line refill, data port, and optional others.
- Grants the bus to one master per bus cycle, holds the grant for the master's whole cyc burst (e.g. an 8-beat line fill), and rotates priority round-robin.
- Includes a watchdog that terminates stalled cycles with an error.
- Sits between the cache/LSU masters and the top-level bus.

---
 rtl/wb_master_arbiter_pkg.sv | 14 +
 rtl/wb_master_arbiter_if.sv | 27 ++
 rtl/wb_master_arbiter_pick.sv | 29 ++
 rtl/wb_master_arbiter.sv | 110 +++++++++++
 tb/tb_wb_master_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_master_arbiter_pkg.sv
// Shared bus geometry and arbiter state encoding.
// Also consumed by the cache masters.
package wb_master_arbiter_pkg;

  localparam int RW = 16;
  localparam int AW = 24;
  localparam int SW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

endpackage

// File: rtl/wb_master_arbiter_if.sv
// Top-level Wishbone bus seen from the arbiter.
// Read data bypasses the arbiter entirely.
interface wb_master_arbiter_if;
  import wb_master_arbiter_pkg::*;

  logic          wb_cyc;
  logic          wb_stb;
  logic          wb_we;
  logic [AW-1:0] wb_adr;
  logic [RW-1:0] wb_o_dat;
  logic [SW-1:0] wb_sel;
  logic          wb_ack;
  logic          wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we,
    output wb_adr, wb_o_dat, wb_sel,
    input  wb_ack, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we,
    input  wb_adr, wb_o_dat, wb_sel,
    output wb_ack, wb_err
  );

endinterface

// File: rtl/wb_master_arbiter_pick.sv
// Cyclic priority search: first requester at or
// after the round-robin pointer.
module wb_master_arbiter_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] ptr_i,
  output logic [GW-1:0] gnt_o,
  output logic          vld_o
);

  int k;

  // Walk from farthest to nearest so the nearest wins.
  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    k     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % N;
      if (req_i[k]) begin
        gnt_o = GW'(k);
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_master_arbiter.sv
// Round-robin Wishbone master arbiter with
// burst-hold grant and stall watchdog.
module wb_master_arbiter
  import wb_master_arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int TMO_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N-1:0]      m_cyc,
  input  logic [N-1:0]      m_stb,
  input  logic [N-1:0]      m_we,
  input  logic [N*AW-1:0]   m_adr,
  input  logic [N*RW-1:0]   m_o_dat,
  input  logic [N*SW-1:0]   m_sel,
  output logic [N-1:0]      m_ack,
  output logic [N-1:0]      m_err,
  wb_master_arbiter_if.master bus
);

  localparam int GW = (N > 1) ? $clog2(N) : 1;
  localparam logic [TMO_W-1:0] WD_MAX = '1;

  state_e            state_q, state_d;
  logic [GW-1:0]     gnt_q, gnt_d;
  logic [GW-1:0]     rr_q, rr_d;
  logic [TMO_W-1:0]  wd_q, wd_d;

  logic [GW-1:0]     pick;
  logic              pick_vld;
  logic [GW-1:0]     rr_inc;
  logic              busy, g_cyc, g_stb, tmo;

  wb_master_arbiter_pick #(
    .N  (N),
    .GW (GW)
  ) u_pick (
    .req_i (m_cyc),
    .ptr_i (rr_q),
    .gnt_o (pick),
    .vld_o (pick_vld)
  );

  assign busy   = (state_q == BUSY);
  assign g_cyc  = m_cyc[gnt_q];
  assign g_stb  = m_stb[gnt_q];
  assign rr_inc = (gnt_q == GW'(N - 1)) ? '0 : gnt_q + 1'b1;

  // A same-cycle ack or err pre-empts the timeout.
  assign tmo = busy & g_stb & (wd_q == WD_MAX)
             & ~bus.wb_ack & ~bus.wb_err;

  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    rr_d         = rr_q;
    wd_d         = '0;
    m_ack        = '0;
    m_err        = '0;
    bus.wb_cyc   = 1'b0;
    bus.wb_stb   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_adr   = '0;
    bus.wb_o_dat = '0;
    bus.wb_sel   = '0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          gnt_d   = pick;
          state_d = BUSY;
        end
      end
      BUSY: begin
        bus.wb_cyc   = g_cyc & ~tmo;
        bus.wb_stb   = g_stb & ~tmo;
        bus.wb_we    = m_we[gnt_q];
        bus.wb_adr   = m_adr[int'(gnt_q)*AW +: AW];
        bus.wb_o_dat = m_o_dat[int'(gnt_q)*RW +: RW];
        bus.wb_sel   = m_sel[int'(gnt_q)*SW +: SW];
        m_ack[gnt_q] = bus.wb_ack;
        m_err[gnt_q] = bus.wb_err | tmo;
        if (!g_cyc || tmo) begin
          state_d = IDLE;
          rr_d    = rr_inc;
        end else if (g_stb && !bus.wb_ack
                     && !bus.wb_err) begin
          wd_d = (wd_q == WD_MAX) ? wd_q
                                  : wd_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      rr_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rr_q    <= rr_d;
      wd_q    <= wd_d;
    end
  end

endmodule

// File: tb/tb_wb_master_arbiter.sv
// Directed bench for wb_master_arbiter with a
// per-cycle ownership model and literal spot checks.
module tb_wb_master_arbiter;
  import wb_master_arbiter_pkg::*;

  localparam int N     = 2;
  localparam int TMO_W = 4;
  localparam int MAXC  = (1 << TMO_W) - 1;

  localparam logic [23:0] A0 = 24'h0A0A0A;
  localparam logic [23:0] A1 = 24'h1B1B1B;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    m_cyc = '0;
  logic [N-1:0]    m_stb = '0;
  logic [N-1:0]    m_we  = 2'b01;
  logic [N*24-1:0] m_adr = {A1, A0};
  logic [N*16-1:0] m_o_dat = {16'h2222, 16'h1111};
  logic [N*2-1:0]  m_sel = {2'b11, 2'b01};
  logic [N-1:0]    m_ack, m_err;

  wb_master_arbiter_if bus ();

  wb_master_arbiter #(
    .N     (N),
    .TMO_W (TMO_W)
  ) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .m_cyc   (m_cyc),
    .m_stb   (m_stb),
    .m_we    (m_we),
    .m_adr   (m_adr),
    .m_o_dat (m_o_dat),
    .m_sel   (m_sel),
    .m_ack   (m_ack),
    .m_err   (m_err),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int bad = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    vec++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 = nobody), next in
  // line, and how many unanswered strobe cycles so far.
  int owner = -1;
  int nxt   = 0;
  int stall = 0;

  function automatic bit tmo_now();
    if (owner < 0) return 1'b0;
    return stall == MAXC && m_stb[owner]
        && !bus.wb_ack && !bus.wb_err;
  endfunction

  always @(posedge clk) begin : model
    int g;
    bit t;
    g = owner;
    t = tmo_now();
    if (rst) begin
      owner = -1;
      nxt   = 0;
      stall = 0;
    end else if (g < 0) begin
      for (int i = N - 1; i >= 0; i--)
        if (m_cyc[(nxt + i) % N]) owner = (nxt + i) % N;
      stall = 0;
    end else if (!m_cyc[g] || t) begin
      owner = -1;
      nxt   = (g + 1) % N;
      stall = 0;
    end else if (m_stb[g] && !bus.wb_ack && !bus.wb_err) begin
      stall = (stall < MAXC) ? stall + 1 : MAXC;
    end else begin
      stall = 0;
    end
  end

  always @(negedge clk) begin : cmp
    int g;
    bit t;
    logic [2:0]  e_ctl;
    logic [23:0] e_adr;
    logic [17:0] e_ds;
    logic [3:0]  e_ae;
    g = owner;
    t = tmo_now();
    e_ctl = '0;
    e_adr = '0;
    e_ds  = '0;
    e_ae  = '0;
    if (g >= 0) begin
      e_ctl = {m_cyc[g] && !t, m_stb[g] && !t, m_we[g]};
      e_adr = m_adr[24*g +: 24];
      e_ds  = {m_o_dat[16*g +: 16], m_sel[2*g +: 2]};
      e_ae  = {bus.wb_ack ? 2'(1 << g) : 2'b00,
               (bus.wb_err || t) ? 2'(1 << g) : 2'b00};
    end
    chk("ctl", {bus.wb_cyc, bus.wb_stb, bus.wb_we}, e_ctl);
    chk("adr", bus.wb_adr, e_adr);
    chk("dat_sel", {bus.wb_o_dat, bus.wb_sel}, e_ds);
    chk("ack_err", {m_ack, m_err}, e_ae);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    bus.wb_ack = 1'b0;
    bus.wb_err = 1'b0;
    repeat (2) step();
    chk("rst_outs", {bus.wb_cyc, bus.wb_stb, m_ack, m_err}, 0);
    rst = 1'b0;

    // Single 8-beat burst from master 0.
    m_cyc = 2'b01; m_stb = 2'b01; bus.wb_ack = 1'b1;
    #1 chk("t1_latency", bus.wb_cyc, 0);
    step();
    for (int b = 0; b < 8; b++) begin
      chk("t1_cyc", bus.wb_cyc, 1);
      chk("t1_ack", m_ack, 2'b01);
      step();
    end
    m_cyc = '0; m_stb = '0; bus.wb_ack = 1'b0;
    #1 chk("t1_end", {bus.wb_cyc, m_ack}, 0);
    step();

    // Simultaneous requests from reset, then wrap.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11; bus.wb_ack = 1'b1;
    step();
    for (int b = 0; b < 3; b++) begin
      chk("t2_m0_adr", bus.wb_adr, A0);
      chk("t2_m0_ack", m_ack, 2'b01);
      step();
    end
    m_cyc = 2'b10; m_stb = 2'b10; bus.wb_ack = 1'b0;
    #1 chk("t2_drop", bus.wb_cyc, 0);
    step();
    chk("t2_gap", bus.wb_cyc, 0);
    bus.wb_ack = 1'b1;
    step();
    for (int b = 0; b < 3; b++) begin
      chk("t2_m1_adr", bus.wb_adr, A1);
      chk("t2_m1_ack", m_ack, 2'b10);
      step();
    end
    m_cyc = '0; m_stb = '0; bus.wb_ack = 1'b0;
    step();
    m_cyc = 2'b11; m_stb = 2'b11; bus.wb_ack = 1'b1;
    step();
    chk("t2_wrap", {bus.wb_cyc, bus.wb_adr}, {1'b1, A0});
    m_cyc = '0; m_stb = '0; bus.wb_ack = 1'b0;
    repeat (2) step();

    // Master 1 requests during master 0 burst.
    m_cyc = 2'b01; m_stb = 2'b01; bus.wb_ack = 1'b1;
    step();
    for (int b = 1; b <= 8; b++) begin
      if (b == 3) begin
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        #1;
      end
      chk("t3_adr", bus.wb_adr, A0);
      chk("t3_m1_wait", m_ack, 2'b01);
      step();
    end
    m_cyc = 2'b10; m_stb = 2'b10; bus.wb_ack = 1'b0;
    step();
    bus.wb_ack = 1'b1;
    step();
    chk("t3_m1_gnt", {bus.wb_cyc, bus.wb_adr}, {1'b1, A1});
    m_cyc = '0; m_stb = '0; bus.wb_ack = 1'b0;
    repeat (2) step();

    // Watchdog timeout with master 1 waiting.
    do_reset();
    m_cyc = 2'b11; m_stb = 2'b11;
    step();
    for (int k = 1; k <= MAXC; k++) begin
      chk("t4_wait", {bus.wb_cyc, m_err}, {1'b1, 2'b00});
      step();
    end
    chk("t4_err", {bus.wb_cyc, bus.wb_stb, m_err},
        {1'b0, 1'b0, 2'b01});
    step();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    #1 chk("t4_idle", {bus.wb_cyc, m_err}, 0);
    step();
    chk("t4_m1_gnt", {bus.wb_cyc, bus.wb_adr}, {1'b1, A1});
    m_cyc = '0; m_stb = '0;
    repeat (2) step();

    // Ack on the very cycle the watchdog saturates.
    do_reset();
    m_cyc = 2'b01; m_stb = 2'b01;
    step();
    repeat (MAXC) step();
    bus.wb_ack = 1'b1;
    #1 chk("t5_ack_wins", {bus.wb_cyc, m_ack, m_err},
           {1'b1, 2'b01, 2'b00});
    step();
    bus.wb_ack = 1'b0;
    #1 chk("t5_cont", {bus.wb_cyc, m_err}, {1'b1, 2'b00});
    step();
    m_cyc = '0; m_stb = '0;
    repeat (2) step();

    // Reset in the middle of a burst.
    do_reset();
    m_cyc = 2'b01; m_stb = 2'b01; bus.wb_ack = 1'b1;
    step();
    repeat (3) step();
    rst = 1'b1;
    #1 chk("t6_pre", m_ack, 2'b01);
    step();
    chk("t6_rst", {bus.wb_cyc, m_ack}, 0);
    rst = 1'b0;
    m_cyc = 2'b10; m_stb = 2'b10;
    step();
    chk("t6_m1_gnt", {bus.wb_cyc, bus.wb_adr}, {1'b1, A1});
    m_cyc = '0; m_stb = '0; bus.wb_ack = 1'b0;
    repeat (2) step();

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, bad);
    $finish;
  end

endmodule
